// File: rtl/mem_ctrl_if.sv
// Data-bus bundle between the MEM-stage controller (master) and the data memory/bus (slave).
interface mem_ctrl_if;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [31:0] bus_wdata_o;
    logic [3:0]  bus_sel_o;
    logic        bus_err_o;
    logic        bus_ack_i;
    logic [31:0] bus_rdata_i;

    modport master (
        output bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_sel_o, bus_err_o,
        input  bus_ack_i, bus_rdata_i
    );

    modport slave (
        input  bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_sel_o, bus_err_o,
        output bus_ack_i, bus_rdata_i
    );
endinterface

// File: rtl/mem_ctrl.sv
// MEM-stage data-access controller: one registered bus transaction per request, stalls the pipe.
// Optional bus-wait abort enabled by defining MEM_CTRL_TIMEOUT_EN.
module mem_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_req_i,
    input  logic        mem_we_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wdata_i,
    input  logic [3:0]  mem_sel_i,
    output logic [31:0] mem_rdata_o,
    output logic        stall_req_o,
    mem_ctrl_if.master  bus
);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e      state_q, state_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  sel_q, sel_d;
    logic [31:0] rdata_q, rdata_d;

`ifdef MEM_CTRL_TIMEOUT_EN
    localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            err_q, err_d;
`endif

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        sel_d   = sel_q;
        rdata_d = rdata_q;
`ifdef MEM_CTRL_TIMEOUT_EN
        cnt_d   = cnt_q;
        err_d   = 1'b0;
`endif
        case (state_q)
            StIdle: begin
                if (mem_req_i) begin
                    state_d = StBusy;
                    req_d   = 1'b1;
                    we_d    = mem_we_i;
                    addr_d  = mem_addr_i;
                    wdata_d = mem_wdata_i;
                    sel_d   = mem_sel_i;
`ifdef MEM_CTRL_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            StBusy: begin
                // Ack wins over a timeout landing in the same cycle.
                if (bus.bus_ack_i) begin
                    state_d = StDone;
                    req_d   = 1'b0;
                    if (!we_q) begin
                        rdata_d = bus.bus_rdata_i;
                    end
`ifdef MEM_CTRL_TIMEOUT_EN
                end else if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
                    state_d = StDone;
                    req_d   = 1'b0;
                    rdata_d = '0;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
`endif
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            sel_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            sel_q   <= sel_d;
            rdata_q <= rdata_d;
        end
    end

`ifdef MEM_CTRL_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign bus.bus_err_o = err_q;
`else
    assign bus.bus_err_o = 1'b0;
`endif

    assign stall_req_o     = ((state_q == StIdle) && mem_req_i) || (state_q == StBusy);
    assign mem_rdata_o     = rdata_q;
    assign bus.bus_req_o   = req_q;
    assign bus.bus_we_o    = we_q;
    assign bus.bus_addr_o  = addr_q;
    assign bus.bus_wdata_o = wdata_q;
    assign bus.bus_sel_o   = sel_q;

endmodule
